// File: rtl/imgproc_bgsub_pipe.sv
// Pipelined background subtraction: scans a frame, thresholds |pixel - background| per lane, counts pixels.
// Optional BG_UPDATE_EN macro enables the running-average background write-back.
module imgproc_bgsub_pipe #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 16,
    parameter int ADDR_W       = 13,
    parameter int NUM_WORDS    = 8192,
    parameter int RD_LAT       = 1,
    parameter int CNT_W        = 16,
    parameter int ALPHA_SHIFT  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [2:0]                    currentFrame,
    input  logic [PIX_W-1:0]              threshold,
    input  logic [PIX_W*PIX_PER_WORD-1:0] readPixel,
    input  logic [PIX_W*PIX_PER_WORD-1:0] bgPixel,
    output logic                          readEn,
    output logic [ADDR_W-1:0]             readAddress,
    output logic                          writeEn,
    output logic [ADDR_W-1:0]             writeAddress,
    output logic [PIX_W*PIX_PER_WORD-1:0] subtractedPixel,
    output logic                          bgWriteEn,
    output logic [PIX_W*PIX_PER_WORD-1:0] bgWriteData,
    output logic                          busy,
    output logic                          done,
    output logic [2:0]                    doneFrame,
    output logic [CNT_W-1:0]              goodCnt,
    output logic [CNT_W-1:0]              badCnt
);
    localparam int W       = PIX_W * PIX_PER_WORD;
    localparam int LANE_CW = $clog2(PIX_PER_WORD + 1);
    localparam int SUM_W   = CNT_W + LANE_CW;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [SUM_W-1:0]  CNT_MAX   = {{LANE_CW{1'b0}}, {CNT_W{1'b1}}};

    if (RD_LAT < 1 || RD_LAT > 3 || NUM_WORDS < 1 || NUM_WORDS > (1 << ADDR_W) ||
        ALPHA_SHIFT < 0 || ALPHA_SHIFT > PIX_W) begin : gBadParams
        $error("imgproc_bgsub_pipe: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} stateT;
    stateT state, nextState;

    logic [RD_LAT-1:0] vPipe;
    logic [ADDR_W-1:0] aPipe [RD_LAT];
    logic [2:0]        latchedFrame;
    logic [PIX_W-1:0]  latchedThr;

    logic [PIX_W-1:0]   pixLane, bgLane, diffLane;
    logic [LANE_CW-1:0] fgCount, bgCount;
    logic [W-1:0]       maskedWord;

    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a, input logic [LANE_CW-1:0] b);
        logic [SUM_W-1:0] s;
        s = {{LANE_CW{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        return (s > CNT_MAX) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // DRAIN ends once the last issued word has left the read pipe (it is being written this cycle).
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = SCAN;
            SCAN:    if (readAddress == LAST_ADDR) nextState = DRAIN;
            DRAIN:   if (vPipe == '0) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        readEn = (state == SCAN);
        busy   = (state != IDLE);
        done   = (state == DONE);
    end

    always_comb begin
        maskedWord = '0;
        fgCount    = '0;
        pixLane    = '0;
        bgLane     = '0;
        diffLane   = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            pixLane  = readPixel[i*PIX_W +: PIX_W];
            bgLane   = bgPixel[i*PIX_W +: PIX_W];
            diffLane = (pixLane >= bgLane) ? pixLane - bgLane : bgLane - pixLane;
            if (diffLane >= latchedThr) begin
                maskedWord[i*PIX_W +: PIX_W] = diffLane;
                fgCount = fgCount + LANE_CW'(1);
            end
        end
    end
    assign bgCount = LANE_CW'(PIX_PER_WORD) - fgCount;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            readAddress     <= '0;
            vPipe           <= '0;
            for (int i = 0; i < RD_LAT; i++) aPipe[i] <= '0;
            writeEn         <= 1'b0;
            writeAddress    <= '0;
            subtractedPixel <= '0;
            goodCnt         <= '0;
            badCnt          <= '0;
            doneFrame       <= '0;
            latchedFrame    <= '0;
            latchedThr      <= '0;
        end else begin
            if (state == IDLE && start) begin
                latchedFrame <= currentFrame;
                latchedThr   <= threshold;
                goodCnt      <= '0;
                badCnt       <= '0;
                readAddress  <= '0;
            end else if (state == SCAN && readAddress != LAST_ADDR) begin
                readAddress <= readAddress + 1'b1;
            end
            vPipe[0] <= readEn;
            aPipe[0] <= readAddress;
            for (int i = 1; i < RD_LAT; i++) begin
                vPipe[i] <= vPipe[i-1];
                aPipe[i] <= aPipe[i-1];
            end
            writeEn <= vPipe[RD_LAT-1];
            if (vPipe[RD_LAT-1]) begin
                writeAddress    <= aPipe[RD_LAT-1];
                subtractedPixel <= maskedWord;
                goodCnt         <= satAdd(goodCnt, bgCount);
                badCnt          <= satAdd(badCnt, fgCount);
            end
            if (nextState == DONE) doneFrame <= latchedFrame;
        end
    end

`ifdef BG_UPDATE_EN
    logic signed [PIX_W+1:0] delta, updLane;
    logic [W-1:0]            bgNext;

    // Floor-shifted step toward the pixel, clamped back into the unsigned lane range.
    always_comb begin
        bgNext  = '0;
        delta   = '0;
        updLane = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            delta   = $signed({2'b00, readPixel[i*PIX_W +: PIX_W]}) - $signed({2'b00, bgPixel[i*PIX_W +: PIX_W]});
            updLane = $signed({2'b00, bgPixel[i*PIX_W +: PIX_W]}) + (delta >>> ALPHA_SHIFT);
            if (updLane[PIX_W+1])    bgNext[i*PIX_W +: PIX_W] = '0;
            else if (updLane[PIX_W]) bgNext[i*PIX_W +: PIX_W] = {PIX_W{1'b1}};
            else                     bgNext[i*PIX_W +: PIX_W] = updLane[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bgWriteEn   <= 1'b0;
            bgWriteData <= '0;
        end else begin
            bgWriteEn <= vPipe[RD_LAT-1];
            if (vPipe[RD_LAT-1]) bgWriteData <= bgNext;
        end
    end
`else
    assign bgWriteEn   = 1'b0;
    assign bgWriteData = '0;
`endif

endmodule

// File: tb/tb_imgproc_bgsub_pipe.sv
// Bench for imgproc_bgsub_pipe: two instances (RD_LAT=1/CNT_W=16 and RD_LAT=3/CNT_W=4) checked against a lane-level model.
module tb_imgproc_bgsub_pipe;
    localparam int W  = 128;
    localparam int NW = 4;
    localparam int AW = 13;
    localparam logic [W-1:0] PIX_A   = 128'h01ff45008900cd0001ff45008900cd00;
    localparam logic [W-1:0] BG_A    = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [W-1:0] LIT_SUB = 128'h00dc006700ab00ef00dc006700ab00ef;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start;
    logic [2:0] currentFrame;
    logic [7:0] threshold;
    logic [W-1:0] frameMem [NW];
    logic [W-1:0] bgMem [NW];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rdEn0, we0, bwe0, busy0, done0;
    logic [AW-1:0] rdAddr0, wa0;
    logic [W-1:0] rp0, bp0, sp0, bwd0;
    logic [2:0] df0;
    logic [15:0] gc0, bc0;

    logic rdEn1, we1, bwe1, busy1, done1;
    logic [AW-1:0] rdAddr1, wa1;
    logic [W-1:0] rp1, bp1, sp1, bwd1;
    logic [2:0] df1;
    logic [3:0] gc1, bc1;

    imgproc_bgsub_pipe #(.NUM_WORDS(NW), .RD_LAT(1), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .currentFrame(currentFrame), .threshold(threshold),
        .readPixel(rp0), .bgPixel(bp0), .readEn(rdEn0), .readAddress(rdAddr0), .writeEn(we0),
        .writeAddress(wa0), .subtractedPixel(sp0), .bgWriteEn(bwe0), .bgWriteData(bwd0),
        .busy(busy0), .done(done0), .doneFrame(df0), .goodCnt(gc0), .badCnt(bc0));

    imgproc_bgsub_pipe #(.NUM_WORDS(NW), .RD_LAT(3), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .currentFrame(currentFrame), .threshold(threshold),
        .readPixel(rp1), .bgPixel(bp1), .readEn(rdEn1), .readAddress(rdAddr1), .writeEn(we1),
        .writeAddress(wa1), .subtractedPixel(sp1), .bgWriteEn(bwe1), .bgWriteData(bwd1),
        .busy(busy1), .done(done1), .doneFrame(df1), .goodCnt(gc1), .badCnt(bc1));

    // RAM models: data of the addressed word appears RD_LAT cycles after the address.
    logic [1:0] a1d1, a1d2;
    always @(posedge clk) begin
        rp0  <= frameMem[rdAddr0[1:0]];
        bp0  <= bgMem[rdAddr0[1:0]];
        a1d1 <= rdAddr1[1:0];
        a1d2 <= a1d1;
        rp1  <= frameMem[a1d2];
        bp1  <= bgMem[a1d2];
    end

    int nTests = 0, nFails = 0;
    int issueNext [2], nextAddr [2], doneCnt [2], expGood [2], expBad [2];
    int issueCyc [2][NW];
    logic [7:0] frameThr;
    logic [2:0] frameId;
    logic [W-1:0] lastSub [2];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] modelSub(input logic [W-1:0] p, input logic [W-1:0] b, input logic [7:0] t);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            int pv, bv, d;
            pv = int'(p[i*8 +: 8]);
            bv = int'(b[i*8 +: 8]);
            d  = (pv > bv) ? pv - bv : bv - pv;
            if (d >= int'(t)) r[i*8 +: 8] = 8'(d);
        end
        return r;
    endfunction

    function automatic int modelFg(input logic [W-1:0] p, input logic [W-1:0] b, input logic [7:0] t);
        int n, pv, bv, d;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            pv = int'(p[i*8 +: 8]);
            bv = int'(b[i*8 +: 8]);
            d  = (pv > bv) ? pv - bv : bv - pv;
            if (d >= int'(t)) n++;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] modelBg(input logic [W-1:0] p, input logic [W-1:0] b);
        logic [W-1:0] r;
        int pv, bv, u;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            pv = int'(p[i*8 +: 8]);
            bv = int'(b[i*8 +: 8]);
            u  = bv + ((pv - bv) >>> 3);
            if (u < 0) u = 0;
            if (u > 255) u = 255;
            r[i*8 +: 8] = 8'(u);
        end
        return r;
    endfunction

    task automatic onCycle(input int g, input int lat, input logic rEn, input logic [AW-1:0] rA,
                           input logic wE, input logic [AW-1:0] wA, input logic [W-1:0] sub,
                           input logic bwE, input logic [W-1:0] bwD, input logic dn,
                           input logic [2:0] dF, input int gC, input int bC);
        int idx;
        idx = nextAddr[g] % NW;
        if (rEn) begin
            check($sformatf("read_addr%0d", g), W'(rA), W'(issueNext[g]));
            issueCyc[g][issueNext[g] % NW] = cyc;
            issueNext[g]++;
        end
`ifdef BG_UPDATE_EN
        check($sformatf("bg_we%0d", g), W'(bwE), W'(wE));
`else
        check($sformatf("bg_tied%0d", g), {bwD[W-2:0], bwE}, '0);
`endif
        if (wE) begin
            check($sformatf("write_addr%0d", g), W'(wA), W'(nextAddr[g]));
            check($sformatf("write_latency%0d", g), W'(cyc - issueCyc[g][idx]), W'(lat + 1));
            check($sformatf("sub_word%0d", g), sub, modelSub(frameMem[idx], bgMem[idx], frameThr));
`ifdef BG_UPDATE_EN
            check($sformatf("bg_word%0d", g), bwD, modelBg(frameMem[idx], bgMem[idx]));
`endif
            lastSub[g] = sub;
            nextAddr[g]++;
        end
        if (dn) begin
            doneCnt[g]++;
            check($sformatf("done_words%0d", g), W'(nextAddr[g]), W'(NW));
            check($sformatf("good_cnt%0d", g), W'(gC), W'(expGood[g]));
            check($sformatf("bad_cnt%0d", g), W'(bC), W'(expBad[g]));
            check($sformatf("done_frame%0d", g), W'(dF), W'(frameId));
        end
    endtask

    always @(negedge clk) begin
        onCycle(0, 1, rdEn0, rdAddr0, we0, wa0, sp0, bwe0, bwd0, done0, df0, int'(gc0), int'(bc0));
        onCycle(1, 3, rdEn1, rdAddr1, we1, wa1, sp1, bwe1, bwd1, done1, df1, int'(gc1), int'(bc1));
    end

    task automatic kick(input logic [7:0] thr, input logic [2:0] fr);
        int bad;
        bad = 0;
        for (int a = 0; a < NW; a++) bad += modelFg(frameMem[a], bgMem[a], thr);
        frameThr = thr;
        frameId  = fr;
        for (int g = 0; g < 2; g++) begin
            issueNext[g] = 0;
            nextAddr[g]  = 0;
        end
        expBad[0]  = (bad > 65535) ? 65535 : bad;
        expGood[0] = (NW * 16 - bad > 65535) ? 65535 : NW * 16 - bad;
        expBad[1]  = (bad > 15) ? 15 : bad;
        expGood[1] = (NW * 16 - bad > 15) ? 15 : NW * 16 - bad;
        threshold    = thr;
        currentFrame = fr;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int d0, input int d1);
        int n;
        n = 0;
        while ((doneCnt[0] == d0 || doneCnt[1] == d1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", W'(n < 100), W'(1));
        repeat (5) @(negedge clk);
        check("one_done0", W'(doneCnt[0]), W'(d0 + 1));
        check("one_done1", W'(doneCnt[1]), W'(d1 + 1));
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ctl0"}, W'({rdEn0, we0, busy0, done0, bwe0, gc0, bc0, df0, rdAddr0, wa0}), '0);
        check({tag, "_data0"}, sp0 | bwd0, '0);
        check({tag, "_ctl1"}, W'({rdEn1, we1, busy1, done1, bwe1, gc1, bc1, df1, rdAddr1, wa1}), '0);
        check({tag, "_data1"}, sp1 | bwd1, '0);
    endtask

    task automatic holdMem();
        for (int a = 0; a < NW; a++) begin
            frameMem[a] = PIX_A;
            bgMem[a]    = BG_A;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1, n;
        for (int g = 0; g < 2; g++) begin
            issueNext[g] = 0; nextAddr[g] = 0; doneCnt[g] = 0; expGood[g] = 0; expBad[g] = 0;
            lastSub[g] = '0;
        end
        frameThr = '0; frameId = '0;
        rst_n = 1'b0; start = 1'b0; threshold = '0; currentFrame = '0;
        holdMem();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Held data, threshold 0x10: half the lanes foreground.
        d0 = doneCnt[0]; d1 = doneCnt[1];
        kick(8'h10, 3'd3);
        waitDone(d0, d1);
        check("t10_sub", lastSub[0], LIT_SUB);
        check("t10_good0", W'(gc0), W'(32));
        check("t10_bad0", W'(bc0), W'(32));
        check("t10_sat1", W'({gc1, bc1}), W'(8'hff));
        check("t10_idle", W'({busy0, busy1}), '0);

        // Threshold 0: every lane foreground; 4-bit counter saturates.
        d0 = doneCnt[0]; d1 = doneCnt[1];
        kick(8'h00, 3'd1);
        waitDone(d0, d1);
        check("t00_sub", lastSub[0], LIT_SUB);
        check("t00_bad0", W'(bc0), W'(64));
        check("t00_good0", W'(gc0), W'(0));
        check("t00_bad1", W'(bc1), W'(15));
        check("t00_good1", W'(gc1), W'(0));

        // Threshold 0xf0: everything background.
        d0 = doneCnt[0]; d1 = doneCnt[1];
        kick(8'hf0, 3'd7);
        waitDone(d0, d1);
        check("tf0_sub", lastSub[0], '0);
        check("tf0_good0", W'(gc0), W'(64));
        check("tf0_bad0", W'(bc0), W'(0));
        check("tf0_frame", W'(df0), W'(7));

        // Address-keyed data; a start during SCAN must not change threshold or frame.
        frameMem[0] = 128'h00112233445566778899aabbccddeeff;
        frameMem[1] = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        frameMem[2] = 128'h80808080404040407f7f7f7f00000000;
        frameMem[3] = 128'h0123456789abcdeffedcba9876543210;
        bgMem[0]    = 128'h10101010101010101010101010101010;
        bgMem[1]    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        bgMem[2]    = 128'h7f7f7f7f80808080404040400000ffff;
        bgMem[3]    = 128'h0123456789abcdef0123456789abcdef;
        d0 = doneCnt[0]; d1 = doneCnt[1];
        kick(8'h40, 3'd6);
        @(negedge clk);
        threshold = 8'h00; currentFrame = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(d0, d1);
        check("keyed_frame0", W'(df0), W'(6));
        check("keyed_frame1", W'(df1), W'(6));

        // start coinciding with DONE is dropped.
        d0 = doneCnt[0]; d1 = doneCnt[1];
        kick(8'h20, 3'd2);
        n = 0;
        while (!done0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", W'(done0), W'(1));
        start = 1'b1; threshold = 8'h00;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done", W'(busy0), W'(0));
        waitDone(d0, d1);
        check("after_done_idle", W'({busy0, busy1}), '0);

        // Reset mid-scan aborts with no done; a fresh frame then runs cleanly.
        holdMem();
        d0 = doneCnt[0]; d1 = doneCnt[1];
        kick(8'h10, 3'd4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_nodone0", W'(doneCnt[0]), W'(d0));
        check("abort_nodone1", W'(doneCnt[1]), W'(d1));
        kick(8'h10, 3'd5);
        waitDone(d0, d1);
        check("fresh_good0", W'(gc0), W'(32));
        check("fresh_bad0", W'(bc0), W'(32));
        check("fresh_frame0", W'(df0), W'(5));

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end
endmodule
